// File: rtl/approx_mul_arbiter_pkg.sv
// Shared widths, the output FIFO entry type and the round-robin pick helper
// for the four-requester 8x8 multiplier.
package approx_mul_arbiter_pkg;

    localparam int NREQ   = 4;
    localparam int TAG_W  = 2;
    localparam int DATA_W = 8;
    localparam int PROD_W = 16;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [PROD_W-1:0] z;
        logic              approx;
    } fifo_entry_t;

    // One-hot grant of the first valid requester after 'last', wrapping mod NREQ.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0]  valid,
                                                input logic [TAG_W-1:0] last);
        logic [NREQ-1:0]  grant;
        logic [TAG_W-1:0] cand;
        grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last + TAG_W'(k);
            if (grant == '0 && valid[cand]) begin
                grant[cand] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/approx_mul8_core.sv
// Combinational 8x8 multiplier: exact product, or an approximation that drops
// the two low multiplicand rows and patches them with a few OR/AND terms.
module approx_mul8_core
    import approx_mul_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              approx,
    output logic [PROD_W-1:0] z
);

    logic [PROD_W-1:0] exact;
    logic [PROD_W-1:0] trunc;
    logic [PROD_W-1:0] a_term;
    logic [PROD_W-1:0] b_term;

    // Rows 0 and 1 are y gated by x[0] and x[1]; only a few of their bits survive.
    always_comb begin
        exact     = PROD_W'(x) * PROD_W'(y);
        trunc     = (PROD_W'(x[DATA_W-1:2]) * PROD_W'(y)) << 2;
        a_term    = '0;
        a_term[6] = (y[6] & x[0]) | (y[4] & x[1]);
        a_term[7] = (y[7] & x[0]) | (y[6] & x[1]);
        a_term[8] = (y[7] & x[0]) & (y[6] & x[1]);
        b_term    = '0;
        b_term[6] = (y[5] & x[0]) | (y[5] & x[1]);
        b_term[8] = y[7] & x[1];
        z         = approx ? (trunc + a_term + b_term) : exact;
    end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter feeding a two-stage multiply pipeline and an output FIFO,
// with credit-based flow control so accepted work always has a FIFO slot.
module approx_mul_arbiter
    import approx_mul_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_x,
    input  logic [NREQ*DATA_W-1:0]   req_y,
    input  logic                     cfg_approx,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [PROD_W-1:0]        rsp_z,
    output logic                     rsp_approx,
    output logic [15:0]              approx_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CRED_W = PTR_W + 1;

    logic [TAG_W-1:0]  last_grant;
    logic [TAG_W-1:0]  grant_idx;
    logic [NREQ-1:0]   grant;
    logic              can_accept;
    logic              accept;
    logic              retire;
    logic [CRED_W-1:0] credit;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_x;
    logic [DATA_W-1:0] s1_y;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_approx;
    logic [PROD_W-1:0] core_z;

    logic              s2_valid;
    fifo_entry_t       s2_entry;

    fifo_entry_t       fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    fifo_entry_t       head;

    // Ready depends only on req_valid, the grant pointer and the credit count.
    always_comb begin
        grant     = rr_pick(req_valid, last_grant);
        grant_idx = last_grant;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = TAG_W'(i);
            end
        end
        can_accept = rst_n && (credit < CRED_W'(FIFO_DEPTH));
        req_ready  = can_accept ? grant : '0;
        accept     = |req_ready;
        retire     = rsp_valid & rsp_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= TAG_W'(NREQ - 1);
            credit     <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
            end
            if (accept && !retire) begin
                credit <= credit + 1'b1;
            end else if (!accept && retire) begin
                credit <= credit - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_tag    <= '0;
            s1_approx <= 1'b0;
            s2_valid  <= 1'b0;
            s2_entry  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_x      <= req_x[grant_idx*DATA_W +: DATA_W];
                s1_y      <= req_y[grant_idx*DATA_W +: DATA_W];
                s1_tag    <= grant_idx;
                s1_approx <= cfg_approx;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_entry.tag    <= s1_tag;
                s2_entry.z      <= core_z;
                s2_entry.approx <= s1_approx;
            end
        end
    end

    approx_mul8_core u_core (
        .x      (s1_x),
        .y      (s1_y),
        .approx (s1_approx),
        .z      (core_z)
    );

    // Credit guarantees a free slot, so S2 never has to stall on the FIFO.
    always_ff @(posedge clk) begin
        if (s2_valid) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= s2_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            approx_cnt <= '0;
        end else begin
            if (s2_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (rsp_approx && approx_cnt != 16'hFFFF) begin
                    approx_cnt <= approx_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        head       = fifo_mem[rd_ptr[PTR_W-1:0]];
        rsp_valid  = (wr_ptr != rd_ptr);
        rsp_tag    = rsp_valid ? head.tag    : '0;
        rsp_z      = rsp_valid ? head.z      : '0;
        rsp_approx = rsp_valid ? head.approx : 1'b0;
    end

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Self-checking bench for approx_mul_arbiter: a queue-based reference model
// predicts grants, response order/latency, products and the approximate count.
module tb_approx_mul_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        cfg_approx;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_tag;
    logic [15:0] rsp_z;
    logic        rsp_approx;
    logic [15:0] approx_cnt;

    typedef struct {
        int tag;
        int z;
        bit a;
        int t;
    } exp_t;

    exp_t q[$];
    int   m_last;
    int   m_cnt;
    int   step_cnt;
    int   acc_total;
    bit   checking;
    int   n_errors;
    int   n_checks;

    bit          s_accepted;
    int          s_acc_tag;
    bit          s_retired;
    bit          s_rsp_valid;
    logic [15:0] s_rsp_z;
    logic [1:0]  s_rsp_tag;
    logic        s_rsp_approx;

    approx_mul_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .cfg_approx (cfg_approx),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_tag    (rsp_tag),
        .rsp_z      (rsp_z),
        .rsp_approx (rsp_approx),
        .approx_cnt (approx_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Product rules written directly as arithmetic on the partial-product rows.
    function automatic int ref_product(input int x, input int y, input bit a);
        int p0, p1, a_t, b_t;
        if (!a) return x * y;
        p0  = (x & 1) ? y : 0;
        p1  = (x & 2) ? y : 0;
        a_t = ((((p0 >> 6) | (p1 >> 4)) & 1) << 6)
            | ((((p0 >> 7) | (p1 >> 6)) & 1) << 7)
            | ((((p0 >> 7) & (p1 >> 6)) & 1) << 8);
        b_t = ((((p0 >> 5) | (p1 >> 5)) & 1) << 6) | (((p1 >> 7) & 1) << 8);
        return (((x >> 2) * y * 4) + a_t + b_t) % 65536;
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic step();
        logic [3:0] exp_ready;
        bit         exp_rv;
        int         c;
        #1;
        exp_ready = '0;
        if (rst_n && q.size() < DEPTH) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (exp_ready == 0 && req_valid[c]) exp_ready[c] = 1'b1;
            end
        end
        exp_rv       = (q.size() > 0) && (step_cnt - q[0].t >= 3);
        s_rsp_valid  = rsp_valid;
        s_rsp_z      = rsp_z;
        s_rsp_tag    = rsp_tag;
        s_rsp_approx = rsp_approx;
        s_accepted   = 1'b0;
        s_retired    = 1'b0;
        if (checking) begin
            checkOutput("req_ready", req_ready, exp_ready);
            checkOutput("rsp_valid", rsp_valid, exp_rv);
            checkOutput("approx_cnt", approx_cnt, m_cnt);
            if (rsp_valid && q.size() > 0) begin
                checkOutput("rsp_tag", rsp_tag, q[0].tag);
                checkOutput("rsp_z", rsp_z, q[0].z);
                checkOutput("rsp_approx", rsp_approx, q[0].a);
            end
        end
        if (rsp_valid && rsp_ready && q.size() > 0) begin
            if (q[0].a && m_cnt < 65535) m_cnt++;
            void'(q.pop_front());
            s_retired = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                q.push_back('{i, ref_product(int'(req_x[i*8 +: 8]), int'(req_y[i*8 +: 8]), cfg_approx), cfg_approx, step_cnt});
                m_last     = i;
                s_accepted = 1'b1;
                s_acc_tag  = i;
                acc_total++;
            end
        end
        @(negedge clk);
        step_cnt++;
    endtask

    task automatic reset_pulse();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rsp_z", rsp_z, 0);
        checkOutput("rst_rsp_tag", rsp_tag, 0);
        checkOutput("rst_rsp_approx", rsp_approx, 0);
        checkOutput("rst_approx_cnt", approx_cnt, 0);
        q.delete();
        m_last = 3;
        m_cnt  = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'h0;
    endtask

    task automatic drain();
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && q.size() > 0; i++) step();
        checkOutput("drain_empty", q.size(), 0);
        step();
    endtask

    task automatic applyStimulus(input int r, input int x, input int y, input bit a, input int exp_z);
        bit got;
        int n;
        drain();
        req_valid  = 4'b0001 << r;
        req_x      = 32'(x) << (8 * r);
        req_y      = 32'(y) << (8 * r);
        cfg_approx = a;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = s_accepted;
        end
        checkOutput("single_accept", got, 1);
        checkOutput("single_grant", s_acc_tag, r);
        req_valid = 4'h0;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            n++;
            got = s_rsp_valid;
        end
        checkOutput("single_rsp_seen", got, 1);
        // Observation n follows edge N+n-1, where N is the accepting edge.
        checkOutput("single_latency_edges", n - 1, 2);
        checkOutput("single_z", s_rsp_z, exp_z);
        checkOutput("single_tag", s_rsp_tag, r);
        checkOutput("single_approx", s_rsp_approx, a);
    endtask

    initial begin
        int grants[8];
        int n_acc;
        int n_ret;

        n_errors   = 0;
        n_checks   = 0;
        step_cnt   = 0;
        acc_total  = 0;
        checking   = 1'b1;
        rst_n      = 1'b0;
        req_valid  = 4'h0;
        req_x      = '0;
        req_y      = '0;
        cfg_approx = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        reset_pulse();

        applyStimulus(0, 255, 255, 1'b1, 65028);
        applyStimulus(0, 255, 255, 1'b0, 65025);
        applyStimulus(2, 3, 3, 1'b1, 0);
        applyStimulus(1, 200, 100, 1'b0, 20000);

        // Backpressure: exactly DEPTH accepts, then everything stalls until drained.
        drain();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        req_x     = $urandom;
        req_y     = $urandom;
        n_acc     = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_accepted) n_acc++;
        end
        checkOutput("bp_accepts", n_acc, DEPTH);
        checkOutput("bp_ready_low", req_ready, 0);
        checkOutput("bp_hold_z", rsp_z, q[0].z);
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        n_ret     = 0;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            step();
            if (s_retired) n_ret++;
        end
        checkOutput("bp_drained", n_ret, DEPTH);
        req_valid = 4'b0100;
        step();
        checkOutput("bp_resume", s_accepted, 1);

        // Reset with operations spread over S1, S2 and the FIFO.
        drain();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) step();
        req_valid = 4'h0;
        reset_pulse();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Round-robin with every requester busy: expect 0,1,2,3,0,1,2,3.
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            req_x = $urandom;
            req_y = $urandom;
            step();
            grants[i] = s_accepted ? s_acc_tag : -1;
        end
        for (int i = 0; i < 8; i++) checkOutput($sformatf("rr_grant%0d", i), grants[i], i % 4);
        drain();

        for (int i = 0; i < 400; i++) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_x      = $urandom;
            req_y      = $urandom;
            cfg_approx = 1'($urandom % 2);
            rsp_ready  = ($urandom % 4) != 0;
            step();
        end
        drain();

        // Saturation: 0xFFFE approximate retirements, then three more.
        reset_pulse();
        checking   = 1'b0;
        acc_total  = 0;
        cfg_approx = 1'b1;
        rsp_ready  = 1'b1;
        req_valid  = 4'hF;
        for (int i = 0; i < 70000 && acc_total < 65534; i++) begin
            req_x = $urandom;
            req_y = $urandom;
            step();
        end
        req_valid = 4'h0;
        checking  = 1'b1;
        checkOutput("preload_accepts", acc_total, 65534);
        drain();
        checkOutput("cnt_preload", approx_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) applyStimulus(i, 255, 255, 1'b1, 65028);
        drain();
        checkOutput("cnt_saturate", approx_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/approx_mul_arbiter.md
APPROX_MUL_ARBITER -- requirements
Module: approx_mul_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4; output FIFO entries, power of two, minimum 2.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid  in  4  per-requester request valid; bit i is requester i.
REQ-005 req_ready  out  4  per-requester accept; at most one bit high per cycle.
REQ-006 req_x  in  32  multiplicand; requester i uses bits [8i+7:8i].
REQ-007 req_y  in  32  multiplier; requester i uses bits [8i+7:8i].
REQ-008 cfg_approx  in  1  1 selects the approximate product, 0 the exact product; sampled per operation at accept.
REQ-009 rsp_valid  out  1  response valid.
REQ-010 rsp_ready  in  1  response accept.
REQ-011 rsp_tag  out  2  index of the requester that issued the response.
REQ-012 rsp_z  out  16  product.
REQ-013 rsp_approx  out  1  cfg_approx value captured with this operation.
REQ-014 approx_cnt  out  16  saturating count of approximate responses retired.

Function
REQ-015 One multiply shall be accepted per cycle at most; handshake is req_valid[i] & req_ready[i]; rsp handshake is rsp_valid & rsp_ready.
REQ-016 Arbitration shall be round-robin: priority starts at last_grant+1 mod 4; last_grant updates only on an accepted handshake.
REQ-017 req_ready[i] shall depend on req_valid and internal state only, never on req_x/req_y.
REQ-018 Pipeline: S1 registers x, y, tag, approx flag; S2 registers product, tag, flag; S2 writes the output FIFO.
REQ-019 A credit counter shall count operations in S1, S2 and FIFO; accept is allowed only when credit < FIFO_DEPTH; accept and retire in the same cycle leave it unchanged.
REQ-020 Latency: with an empty FIFO, an operation accepted at edge N shall present rsp_valid after edge N+2.
REQ-021 rsp_valid, rsp_tag, rsp_z and rsp_approx shall hold stable while rsp_valid & !rsp_ready; responses retire in accept order.
REQ-022 Exact product: z = x*y, 16 bits.
REQ-023 Approximate product, mod 2^16: z = ((x[7:2]*y) << 2) + A + B, where pi[j] = y[j] & x[i]; A[6] = p0[6]|p1[4]; A[7] = p0[7]|p1[6]; A[8] = p0[7]&p1[6]; B[6] = p0[5]|p1[5]; B[8] = p1[7]; all other A and B bits are 0.
REQ-024 approx_cnt shall increment on each retired response with rsp_approx=1 and saturate at 0xFFFF.
REQ-025 When the FIFO is full and credit is exhausted, all req_ready shall be 0 and no state is lost.
REQ-026 A change of cfg_approx shall affect only operations accepted after the change.

Reset
REQ-027 While rst_n=0: req_ready=0, rsp_valid=0, rsp_tag=0, rsp_z=0, rsp_approx=0, approx_cnt=0, credit=0, FIFO pointers=0, S1/S2 valid=0, last_grant=3 (requester 0 wins first).
REQ-028 Reset asserted mid-operation shall discard all in-flight and buffered operations with no response emitted.

Structure
REQ-029 A shared package shall hold NREQ=4, TAG_W=2, DATA_W=8, PROD_W=16 and the FIFO entry struct (tag, z, approx).
REQ-030 The product function shall be a combinational sub-module, approx_mul8_core, with inputs x, y, approx and output z; the arbiter, pipeline, credit counter and FIFO stay in approx_mul_arbiter.

Verification
REQ-031 cfg_approx=1, requester 0, x=255, y=255 -> rsp_z=65028, rsp_tag=0, rsp_approx=1, rsp_valid 2 cycles after accept; with cfg_approx=0 -> rsp_z=65025.
REQ-032 cfg_approx=1, x=3, y=3 -> rsp_z=0; x=200, y=100 with cfg_approx=0 -> rsp_z=20000.
REQ-033 All four requesters held valid for 8 cycles, rsp_ready=1 -> grants in order 0,1,2,3,0,1,2,3, one per cycle, with tags in the same order.
REQ-034 rsp_ready=0, requesters streaming -> exactly FIFO_DEPTH accepts, then req_ready=0 with outputs stable; rsp_ready=1 -> all responses drain in order and accepts resume.
REQ-035 rst_n pulsed low with 3 operations in flight -> rsp_valid=0 immediately, no stale response after release, requester 0 granted first.
REQ-036 Preload approx_cnt to 0xFFFE via 0xFFFE approximate retirements, then 3 more -> approx_cnt=0xFFFF.
